// File: rtl/mem_pkg.sv
// Shared types for the memory responder slice.
// No logic; typedefs and constants only.
// Imported by the responder top and its testbench.
package mem_pkg;

    localparam int WORD_BITS        = 32;
    localparam int WORD_OFFSET_BITS = 2;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [31:0]          addr_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel bundle between a CPU memory port and the responder.
// Pure wiring, zero latency.
// Valid/ready on both channels; the slave side owns req_ready and the response.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_valid;
    logic                  resp_ready;

    modport master (
        output req_addr, req_valid, resp_ready,
        input  req_ready, resp_data, resp_valid
    );

    modport slave (
        input  req_addr, req_valid, resp_ready,
        output req_ready, resp_data, resp_valid
    );
endinterface

// File: rtl/mem_responder_resp_fifo.sv
// Synchronous response FIFO with a registered head word.
// Push visible at the head one cycle later; modulo-DEPTH pointers, any DEPTH >= 1.
// No internal backpressure: caller must not push when full unless popping.
module resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic             head_upd;
    logic [WIDTH-1:0] head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign rd_ptr_nxt = ptr_inc(rd_ptr);

    // Entry storage: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next head word: the following entry after a pop, or the pushed word when it lands at the head.
    always_comb begin
        head_upd = 1'b0;
        head_nxt = head;
        if (pop) begin
            if (count == CNT_W'(1)) begin
                if (push) begin
                    head_upd = 1'b1;
                    head_nxt = push_data;
                end
            end else begin
                head_upd = 1'b1;
                head_nxt = store[rd_ptr_nxt];
            end
        end else if (push && empty) begin
            head_upd = 1'b1;
            head_nxt = push_data;
        end
    end

    // Head register holds steady unless the head entry changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (head_upd) begin
            head <= head_nxt;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Word-read responder: synchronous array, LATENCY-cycle read pipeline, in-order response FIFO.
// Latency: response valid LATENCY cycles after the request handshake when the FIFO is empty.
// Credit counter caps outstanding reads at FIFO_DEPTH, so response backpressure never drops data.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_responder_if.slave        bus,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    word_t                  mem [2**DEPTH_LOG2];
    logic                   rst_q;
    logic [CNT_W-1:0]       outstanding;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic                   req_ready;
    logic                   req_fire;
    logic                   resp_valid;
    logic                   resp_fire;
    logic                   rd_vld;
    word_t                  rd_dat;
    logic                   push_vld;
    word_t                  push_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_head;
    logic                   unused_addr_bits;

    // Byte address to word index; low offset bits and high alias bits are dropped.
    assign addr             = bus.req_addr;
    assign rd_idx           = addr[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
    assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+WORD_OFFSET_BITS],
                                addr[WORD_OFFSET_BITS-1:0]};

    // Ready depends only on registered state (plus reset), never on the handshake inputs.
    assign req_ready     = !rst && !rst_q && (outstanding < CNT_W'(FIFO_DEPTH));
    assign bus.req_ready = req_ready;
    assign req_fire      = bus.req_valid && req_ready;

    assign resp_valid     = !rst && !fifo_empty;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = fifo_head;
    assign resp_fire      = resp_valid && bus.resp_ready;

    // Delayed reset keeps req_ready low for one extra cycle after reset releases.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Credits: requests in flight or buffered, not yet handed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Preload port; contents survive reset. The read below samples the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= word_t'(wr_data);
        end
    end

    // Array word captured on the fire edge by the first pipeline register (or the FIFO).
    assign rd_vld = req_fire;
    assign rd_dat = mem[rd_idx];

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push_vld = rd_vld;
            assign push_dat = rd_dat;
        end else begin : g_pipe
            logic  stg_vld [LATENCY-1];
            word_t stg_dat [LATENCY-1];

            for (genvar i = 0; i < LATENCY - 1; i++) begin : g_stage
                logic  in_vld;
                word_t in_dat;

                if (i == 0) begin : g_head
                    assign in_vld = rd_vld;
                    assign in_dat = rd_dat;
                end else begin : g_body
                    assign in_vld = stg_vld[i-1];
                    assign in_dat = stg_dat[i-1];
                end

                // Non-stalling stage; reset drops whatever is in flight.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stg_vld[i] <= 1'b0;
                    end else begin
                        stg_vld[i] <= in_vld;
                    end
                    stg_dat[i] <= in_dat;
                end
            end

            assign push_vld = stg_vld[LATENCY-2];
            assign push_dat = stg_dat[LATENCY-2];
        end
    endgenerate

    resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_vld),
        .push_data (DATA_WIDTH'(push_dat)),
        .pop       (resp_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Credit scheme must always leave room for a word leaving the pipeline.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_vld && fifo_full && !resp_fire));
endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a cycle-level reference model.
// The model tracks read-first array contents and a queue of (data, due cycle) responses.
// Reports one summary line; every mismatch prints a FAIL line.
module tb_mem_responder;
    localparam int LAT   = 2;
    localparam int FDEP  = 4;
    localparam int DLOG2 = 10;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [DLOG2-1:0] wr_addr;
    logic [31:0]      wr_data;

    mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (DLOG2),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FDEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk;
    int          n_err;
    int          cyc;
    logic        prev_rst;
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_dat_q [$];
    int          exp_due_q [$];
    logic [31:0] got_q [$];
    int          got_cyc_q [$];
    logic        obs_ready;
    logic        obs_valid;
    logic [31:0] obs_data;
    int          n_fired;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, then step past the edge.
    task automatic tick();
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] a;
        @(negedge clk);
        exp_rdy = !rst && !prev_rst && (exp_dat_q.size() < FDEP);
        exp_vld = !rst && (exp_dat_q.size() > 0) && (exp_due_q[0] <= cyc);
        obs_ready = bus.req_ready;
        obs_valid = bus.resp_valid;
        obs_data  = bus.resp_data;
        chk("req_ready", 32'(obs_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(obs_valid), 32'(exp_vld));
        if (exp_vld && obs_valid) chk("resp_data", obs_data, exp_dat_q[0]);
        if (cyc > 0) chk("outstanding", 32'(dut.outstanding), 32'(exp_dat_q.size()));
        if (obs_valid && bus.resp_ready) begin
            got_q.push_back(obs_data);
            got_cyc_q.push_back(cyc);
        end
        if (obs_ready && bus.req_valid) n_fired++;
        if (exp_vld && bus.resp_ready) begin
            void'(exp_dat_q.pop_front());
            void'(exp_due_q.pop_front());
        end
        if (exp_rdy && bus.req_valid) begin
            a = bus.req_addr;
            exp_dat_q.push_back(ref_mem[a[11:2]]);
            exp_due_q.push_back(cyc + LAT);
        end
        if (wr_en) ref_mem[wr_addr] = wr_data;
        if (rst) begin
            exp_dat_q.delete();
            exp_due_q.delete();
        end
        prev_rst = rst;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = DLOG2'(idx);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int want, input int budget);
        for (int k = 0; k < budget && got_q.size() < want; k++) tick();
    endtask

    initial begin
        logic [31:0] r;
        n_chk = 0; n_err = 0; cyc = 0; prev_rst = 1'b1; n_fired = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset, with a preload issued while reset is held.
        tick();
        chk("rst_ready", 32'(obs_ready), 32'd0);
        chk("rst_valid", 32'(obs_valid), 32'd0);
        preload(5, 32'hDEADBEEF);
        rst = 1'b0;
        tick();
        chk("rst_fall_ready", 32'(obs_ready), 32'd0);

        // Single read: valid only in cycle N+2.
        bus.req_valid = 1'b1; bus.req_addr = 32'h14;
        tick();
        chk("single_fire", 32'(obs_ready), 32'd1);
        bus.req_valid = 1'b0;
        tick();
        chk("single_n1", 32'(obs_valid), 32'd0);
        tick();
        chk("single_n2_vld", 32'(obs_valid), 32'd1);
        chk("single_n2_dat", obs_data, 32'hDEADBEEF);
        tick();
        chk("single_n3", 32'(obs_valid), 32'd0);

        // Streaming 16 back-to-back reads.
        for (int i = 0; i < 16; i++) preload(i, 32'(i * 3));
        got_q.delete(); got_cyc_q.delete(); n_fired = 0;
        for (int i = 0; i < 16; i++) begin
            bus.req_valid = 1'b1; bus.req_addr = 32'(i * 4);
            tick();
        end
        bus.req_valid = 1'b0;
        chk("stream_fires", 32'(n_fired), 32'd16);
        drain(16, 20);
        chk("stream_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("stream_data", got_q[i], 32'(i * 3));
            chk("stream_span", 32'(got_cyc_q[15] - got_cyc_q[0]), 32'd15);
        end

        // Backpressure: four credits, held head word, ready returns one cycle after first pop.
        got_q.delete(); n_fired = 0;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 1'b1; bus.req_addr = 32'((8 + k) * 4);
            tick();
        end
        bus.req_valid = 1'b0;
        chk("bp_fires", 32'(n_fired), 32'd4);
        chk("bp_ready_low", 32'(obs_ready), 32'd0);
        chk("bp_hold", obs_data, 32'd24);
        tick();
        chk("bp_hold2", obs_data, 32'd24);
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_rdy_same", 32'(obs_ready), 32'd0);
        tick();
        chk("bp_rdy_next", 32'(obs_ready), 32'd1);
        drain(4, 10);
        chk("bp_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_order", got_q[i], 32'((8 + i) * 3));

        // Aliased address and read-first collision.
        got_q.delete();
        bus.req_valid = 1'b1; bus.req_addr = 32'h1000_0014;
        tick();
        bus.req_addr = 32'h1C;
        wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        drain(3, 10);
        chk("alias_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("alias_word5", got_q[0], 32'd15);
            chk("read_first_old", got_q[1], 32'd21);
            chk("read_first_new", got_q[2], 32'h1234);
        end

        // Reset with three reads outstanding.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1; bus.req_addr = 32'(i * 4);
            tick();
        end
        bus.req_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(obs_ready), 32'd0);
        chk("mid_rst_valid", 32'(obs_valid), 32'd0);
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        got_q.delete();
        tick();
        chk("post_rst_ready0", 32'(obs_ready), 32'd0);
        tick();
        chk("post_rst_ready1", 32'(obs_ready), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("post_rst_stale", 32'(got_q.size()), 32'd0);
        bus.req_valid = 1'b1; bus.req_addr = 32'h14;
        tick();
        bus.req_valid = 1'b0;
        drain(1, 10);
        chk("post_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("post_rst_data", got_q[0], 32'd15);

        // Random traffic on indices 0..15 with aliasing, preloads and occasional resets.
        for (int k = 0; k < 10000; k++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.resp_ready = ($urandom_range(0, 2) != 0);
            r = $urandom();
            r[11:2] = {6'd0, 4'($urandom_range(0, 15))};
            bus.req_addr = r;
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = DLOG2'($urandom_range(0, 15));
            wr_data = $urandom();
            tick();
        end
        rst = 1'b0; wr_en = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("final_empty", 32'(obs_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
